cordic_sincos_pipe: RTL and testbench
=====================================

# cordic_sincos_pipe

Parametrised, fully pipelined CORDIC rotator producing both cosine and sine of a signed binary angle over the full circle [-pi, pi). It is the next generation of the team's unrolled cosine unit. It adds configurable width and iteration count, a sine output, quadrant folding, a pipeline clock-enable and a result-valid flag. It accepts one angle per cycle and sits in the fixed-point arithmetic datapath ahead of the float conversion blocks.

## Interface
- WIDTH, 32, angle and result width in bits; legal range 16..32
- STAGES, 24, number of CORDIC micro-rotations; legal range 8..WIDTH-2
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  angle valid; sampled every cycle while ce=1
- ce  in  1  pipeline enable; 0 freezes every pipeline register
- angle  in  WIDTH  signed angle, value = angle/2^(WIDTH-1) * pi (0x8000_0000 = -pi, 0x4000_0000 = pi/2, 0x2000_0000 = pi/4 at WIDTH=32)
- cos_out  out  WIDTH  signed Q2.(WIDTH-2), 1.0 = 2^(WIDTH-2)
- sin_out  out  WIDTH  signed Q2.(WIDTH-2)
- done  out  1  cos_out/sin_out valid this cycle

## Operation
- Stage 0 (fold):
  - If angle[W-1:W-2] is 01 or 10, invert angle[W-1] (subtract pi mod 2^W) and set a negate flag carried down the pipe.
  - Otherwise pass the angle through with negate=0.
  - After folding, z lies in [-pi/2, pi/2].
  - x0 = K·2^(WIDTH-2) with K = 0.6072529350 (rounded), y0 = 0, z0 = folded angle.
- Stages 1..STAGES, iteration i = 0..STAGES-1:
  - d = sign(z): +1 if z ≥ 0, else -1.
  - x -= d·(y>>>i); y += d·(x>>>i); z -= d·atan_i.
  - All shifts are arithmetic.
- atan_i = round(atan(2^-i)/pi · 2^31), held as a 32-entry constant table and right-shifted with rounding by 32-WIDTH.
- x/y datapath is WIDTH+2 bits: 2 guard LSBs plus sign headroom. The z datapath is WIDTH bits and wraps mod 2^WIDTH.
- Output stage:
  - Round x/y to nearest to drop the guard bits.
  - Negate both results if the negate flag is set.
  - Register into cos_out/sin_out.
  - Magnitude never exceeds 1.0+tolerance, so negation cannot overflow; no saturation logic.
- A valid bit travels alongside the data in every stage. done is the valid bit of the output register.
- Accuracy:
  - |cos_out - round(cos·2^(W-2))| ≤ 2^(WIDTH-STAGES-1) + STAGES LSB, with the same bound for sin.
  - At defaults this is ≤ 152 LSB.

## Timing
- Latency: exactly STAGES+2 enabled cycles (cycles with ce=1) from the edge sampling start=1 to the edge asserting done; 26 at defaults.
- Throughput: one result per enabled cycle. Back-to-back starts give back-to-back done cycles in input order.
- done is high for exactly one enabled cycle per accepted start. With ce=0 it holds its value along with cos_out/sin_out.
- ce=0:
  - No state changes.
  - start/angle are ignored, not queued.
- Reset values: cos_out = 0, sin_out = 0, done = 0, all valid bits 0.
- Data registers other than the outputs need no reset.
- Reset takes priority over ce and start.
- Reset mid-stream:
  - All in-flight results are discarded.
  - done stays 0 until a start is accepted after reset deasserts, then rises STAGES+2 enabled cycles later.
- start=0 cycles propagate bubbles: done=0 in the corresponding output cycle, and output data is don't-care but stable.

## Test plan
- Reset with start pulsed and angle=0x2000_0000 for 5 cycles -> done=0, cos_out=sin_out=0 throughout; no done for 30 cycles after release.
- angle=0x0000_0000, start for 1 cycle -> done exactly 26 cycles later, cos_out≈0x4000_0000, sin_out≈0x0000_0000 within 152 LSB.
- angle=0x2000_0000 (pi/4) -> cos_out≈sin_out≈0x2D41_3CCD. angle=0x6000_0000 (3pi/4) -> cos_out≈0xD2BE_C333, sin_out≈0x2D41_3CCD.
- angle=0x8000_0000 (-pi) -> cos_out≈0xC000_0000, sin_out≈0. angle=0xC000_0000 (-pi/2) -> cos_out≈0, sin_out≈0xC000_0000.
- Four starts on consecutive cycles (0x0, 0x2000_0000, 0x8000_0000, 0x6000_0000) with ce dropped for 3 cycles after the second:
  - four done pulses in input order;
  - the last two are delayed 3 cycles;
  - outputs hold during the stall;
  - reset asserted during a second burst clears all pending done.
- WIDTH=16, STAGES=14 instance, angle=0x4000 -> done after 16 cycles, cos_out≈0x0000, sin_out≈0x4000 within 16 LSB; random sweep of 1000 angles against a real-valued model within the stated bound.

Source files
------------

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC rotator: one signed binary angle per enabled cycle in,
// cosine and sine in Q2.(WIDTH-2) out STAGES+2 enabled cycles later.
module cordic_sincos_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ce,
    input  logic [WIDTH-1:0] angle,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out,
    output logic             done
);

    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned SH = 32 - WIDTH;
    localparam logic [33:0] K_Q32 = 34'h0_9B74_EDA8;

    // Round-to-nearest right shift of a 32-bit-scaled constant down to WIDTH scale.
    function automatic logic [33:0] rshift_round(input logic [33:0] v);
        return ((v << 1) + (34'd1 << SH)) >> (SH + 1);
    endfunction

    function automatic logic [WIDTH-1:0] atan_w(input int i);
        logic [31:0] t;
        t = 32'h0;
        case (i)
            0:  t = 32'h2000_0000;
            1:  t = 32'h12E4_051E;
            2:  t = 32'h09FB_385B;
            3:  t = 32'h0511_11D4;
            4:  t = 32'h028B_0D43;
            5:  t = 32'h0145_D7E1;
            6:  t = 32'h00A2_F61E;
            7:  t = 32'h0051_7C55;
            8:  t = 32'h0028_BE53;
            9:  t = 32'h0014_5F2F;
            10: t = 32'h000A_2F98;
            11: t = 32'h0005_17CC;
            12: t = 32'h0002_8BE6;
            13: t = 32'h0001_45F3;
            14: t = 32'h0000_A2FA;
            15: t = 32'h0000_517D;
            16: t = 32'h0000_28BE;
            17: t = 32'h0000_145F;
            18: t = 32'h0000_0A30;
            19: t = 32'h0000_0518;
            20: t = 32'h0000_028C;
            21: t = 32'h0000_0146;
            22: t = 32'h0000_00A3;
            23: t = 32'h0000_0051;
            24: t = 32'h0000_0029;
            25: t = 32'h0000_0014;
            26: t = 32'h0000_000A;
            27: t = 32'h0000_0005;
            28: t = 32'h0000_0003;
            29: t = 32'h0000_0001;
            30: t = 32'h0000_0001;
            default: t = 32'h0;
        endcase
        return WIDTH'(rshift_round({2'b00, t}));
    endfunction

    localparam logic signed [XW-1:0] X0 = XW'(rshift_round(K_Q32));

    logic                    in_vld_q;
    logic [WIDTH-1:0]        in_ang_q;
    logic signed [XW-1:0]    x_q [STAGES+1];
    logic signed [XW-1:0]    y_q [STAGES+1];
    logic [WIDTH-1:0]        z_q [STAGES+1];
    logic signed [XW-1:0]    x_d [STAGES+1];
    logic signed [XW-1:0]    y_d [STAGES+1];
    logic [WIDTH-1:0]        z_d [STAGES+1];
    logic [STAGES:0]         neg_q, neg_d;
    logic [STAGES:0]         vld_q, vld_d;
    logic                    fold_c;
    logic [WIDTH-1:0]        cos_r_c, sin_r_c, cos_c, sin_c;

    // Quadrant fold followed by the unrolled micro-rotations.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        neg_d = neg_q;
        vld_d = vld_q;

        fold_c   = in_ang_q[WIDTH-1] ^ in_ang_q[WIDTH-2];
        x_d[0]   = X0;
        y_d[0]   = '0;
        z_d[0]   = {in_ang_q[WIDTH-1] ^ fold_c, in_ang_q[WIDTH-2:0]};
        neg_d[0] = fold_c;
        vld_d[0] = in_vld_q;

        for (int i = 0; i < int'(STAGES); i++) begin
            if (z_q[i][WIDTH-1]) begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + atan_w(i);
            end else begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - atan_w(i);
            end
            neg_d[i+1] = neg_q[i];
            vld_d[i+1] = vld_q[i];
        end
    end

    // Drop the two guard bits with round-to-nearest, then undo the fold.
    always_comb begin
        cos_r_c = WIDTH'((x_q[STAGES] + XW'(2)) >>> 2);
        sin_r_c = WIDTH'((y_q[STAGES] + XW'(2)) >>> 2);
        cos_c   = neg_q[STAGES] ? -cos_r_c : cos_r_c;
        sin_c   = neg_q[STAGES] ? -sin_r_c : sin_r_c;
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            in_ang_q <= angle;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            neg_q    <= neg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_vld_q <= 1'b0;
            vld_q    <= '0;
            done     <= 1'b0;
            cos_out  <= '0;
            sin_out  <= '0;
        end else if (ce) begin
            in_vld_q <= start;
            vld_q    <= vld_d;
            done     <= vld_q[STAGES];
            cos_out  <= cos_c;
            sin_out  <= sin_c;
        end
    end

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Bench for cordic_sincos_pipe: 32/24 and 16/14 instances checked against a
// real-valued sin/cos model with an enabled-cycle scoreboard for timing.
module tb_cordic_sincos_pipe;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset32, start32, ce32;
    logic [31:0] ang32, cos32, sin32;
    logic        done32;
    logic        reset16, start16, ce16;
    logic [15:0] ang16, cos16, sin16;
    logic        done16;

    int errors = 0;
    int checks = 0;

    bit          s_ce  [1100];
    bit          s_st  [1100];
    logic [31:0] s_ang [1100];

    always #5 clk = ~clk;

    cordic_sincos_pipe #(.WIDTH(32), .STAGES(24)) dut32 (
        .clk(clk), .reset(reset32), .start(start32), .ce(ce32), .angle(ang32),
        .cos_out(cos32), .sin_out(sin32), .done(done32)
    );

    cordic_sincos_pipe #(.WIDTH(16), .STAGES(14)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .ce(ce16), .angle(ang16),
        .cos_out(cos16), .sin_out(sin16), .done(done16)
    );

    // Ideal result: angle a (signed, w bits) scaled to Q2.(w-2), rounded.
    function automatic longint ref_trig(input longint a, input int w, input bit is_sin);
        real th, sc, v;
        th = real'(a) * PI / real'(longint'(1) << (w - 1));
        sc = real'(longint'(1) << (w - 2));
        v  = is_sin ? $sin(th) : $cos(th);
        return longint'(v * sc);
    endfunction

    task automatic clear_stim(input int n);
        for (int c = 0; c < n; c++) begin
            s_ce[c] = 1'b1; s_st[c] = 1'b0; s_ang[c] = 32'h0;
        end
    endtask

    // Drives the stimulus arrays into one instance and scores done timing,
    // output hold during stalls, and result accuracy in input order.
    task automatic stream(input bit w16, input int n, input string tag);
        longint      tgt[$];
        logic [31:0] exp_ang[$];
        longint      en, tolv, oc, os, ec, es, a, pc, ps, dc, ds;
        int          w, lat;
        logic        od;
        bit          exp_done;
        en = 0; exp_done = 1'b0; pc = 0; ps = 0;
        w    = w16 ? 16 : 32;
        lat  = w16 ? 16 : 26;
        tolv = w16 ? 16 : 152;
        for (int c = 0; c < n; c++) begin
            if (w16) begin
                ce16 = s_ce[c]; start16 = s_st[c]; ang16 = s_ang[c][15:0];
            end else begin
                ce32 = s_ce[c]; start32 = s_st[c]; ang32 = s_ang[c];
            end
            @(posedge clk); #1;
            if (w16) begin
                od = done16; oc = longint'($signed(cos16)); os = longint'($signed(sin16));
            end else begin
                od = done32; oc = longint'($signed(cos32)); os = longint'($signed(sin32));
            end
            if (s_ce[c]) begin
                en++;
                if (s_st[c]) begin
                    tgt.push_back(en + longint'(lat));
                    exp_ang.push_back(s_ang[c]);
                end
                exp_done = (tgt.size() > 0) && (tgt[0] == en);
            end
            checks++;
            if (od !== exp_done) begin
                errors++;
                $display("FAIL %s done @cycle %0d: got %b want %b", tag, c, od, exp_done);
            end
            if (!s_ce[c] && c > 0) begin
                checks++;
                if (oc !== pc || os !== ps) begin
                    errors++;
                    $display("FAIL %s hold @cycle %0d: got %0d/%0d want %0d/%0d", tag, c, oc, os, pc, ps);
                end
            end
            if (s_ce[c] && exp_done) begin
                a  = w16 ? longint'($signed(exp_ang[0][15:0])) : longint'($signed(exp_ang[0]));
                ec = ref_trig(a, w, 1'b0);
                es = ref_trig(a, w, 1'b1);
                dc = oc - ec; if (dc < 0) dc = -dc;
                ds = os - es; if (ds < 0) ds = -ds;
                checks++;
                if (dc > tolv) begin
                    errors++;
                    $display("FAIL %s cos angle=%h: got %0d want %0d +-%0d", tag, exp_ang[0], oc, ec, tolv);
                end
                checks++;
                if (ds > tolv) begin
                    errors++;
                    $display("FAIL %s sin angle=%h: got %0d want %0d +-%0d", tag, exp_ang[0], os, es, tolv);
                end
                void'(tgt.pop_front());
                void'(exp_ang.pop_front());
            end
            pc = oc; ps = os;
        end
        if (w16) begin start16 = 1'b0; ce16 = 1'b1; end
        else begin start32 = 1'b0; ce32 = 1'b1; end
        checks++;
        if (tgt.size() != 0) begin
            errors++;
            $display("FAIL %s missing done: got %0d pending want 0", tag, tgt.size());
        end
    endtask

    task automatic test_reset();
        reset32 = 1'b1; reset16 = 1'b1; ce32 = 1'b1; ce16 = 1'b1;
        start32 = 1'b1; start16 = 1'b1; ang32 = 32'h2000_0000; ang16 = 16'h2000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done32 !== 1'b0 || cos32 !== 32'h0 || sin32 !== 32'h0) begin
                errors++;
                $display("FAIL reset32 state: got done=%b cos=%h sin=%h want 0/0/0", done32, cos32, sin32);
            end
            checks++;
            if (done16 !== 1'b0 || cos16 !== 16'h0 || sin16 !== 16'h0) begin
                errors++;
                $display("FAIL reset16 state: got done=%b cos=%h sin=%h want 0/0/0", done16, cos16, sin16);
            end
        end
        reset32 = 1'b0; reset16 = 1'b0; start32 = 1'b0; start16 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done32 !== 1'b0 || done16 !== 1'b0) begin
                errors++;
                $display("FAIL post_reset done @cycle %0d: got %b/%b want 0/0", c, done32, done16);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] angs [8];
        angs = '{32'h0000_0000, 32'h2000_0000, 32'h6000_0000, 32'h8000_0000,
                 32'hC000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 32'hA000_0000};
        foreach (angs[k]) begin
            clear_stim(32);
            s_st[0] = 1'b1; s_ang[0] = angs[k];
            stream(1'b0, 32, "directed");
        end
    endtask

    task automatic test_stall_burst();
        clear_stim(45);
        s_st[0] = 1'b1; s_ang[0] = 32'h0000_0000;
        s_st[1] = 1'b1; s_ang[1] = 32'h2000_0000;
        for (int c = 2; c < 5; c++) begin
            s_ce[c] = 1'b0; s_st[c] = 1'b1; s_ang[c] = $urandom;
        end
        s_st[5] = 1'b1; s_ang[5] = 32'h8000_0000;
        s_st[6] = 1'b1; s_ang[6] = 32'h6000_0000;
        stream(1'b0, 45, "stall");
    endtask

    task automatic test_reset_midstream();
        ce32 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            start32 = 1'b1; ang32 = $urandom;
            @(posedge clk); #1;
        end
        start32 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset32 = 1'b1; start32 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done32 !== 1'b0 || cos32 !== 32'h0 || sin32 !== 32'h0) begin
                errors++;
                $display("FAIL midreset state: got done=%b cos=%h sin=%h want 0/0/0", done32, cos32, sin32);
            end
        end
        reset32 = 1'b0; start32 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            checks++;
            if (done32 !== 1'b0) begin
                errors++;
                $display("FAIL midreset flush @cycle %0d: got done=%b want 0", c, done32);
            end
        end
        clear_stim(32);
        s_st[0] = 1'b1; s_ang[0] = 32'h2000_0000;
        stream(1'b0, 32, "after_reset");
    endtask

    task automatic test_back_to_back();
        clear_stim(340);
        for (int c = 0; c < 300; c++) begin
            s_ce[c]  = ($urandom_range(0, 99) < 85);
            s_st[c]  = ($urandom_range(0, 9) != 0);
            s_ang[c] = $urandom;
        end
        stream(1'b0, 340, "random32");
    endtask

    task automatic test_width16();
        clear_stim(24);
        s_st[0] = 1'b1; s_ang[0] = 32'h0000_4000;
        stream(1'b1, 24, "w16_directed");
        clear_stim(1030);
        for (int c = 0; c < 1000; c++) begin
            s_st[c] = 1'b1; s_ang[c] = {16'h0, 16'($urandom)};
        end
        stream(1'b1, 1030, "w16_sweep");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_burst();
        test_reset_midstream();
        test_back_to_back();
        test_width16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
